// File: rtl/afifo_pkt_pkg.sv
// Shared definitions for the async-FIFO packet framer (writer) and deframer (reader):
// FSM states, word tags and the trailer-word layout.
package afifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2,
        TRAIL   = 2'd3
    } pkt_state_t;

    localparam logic TAG_PAYLOAD = 1'b0;
    localparam logic TAG_TRAILER = 1'b1;

    // Trailer layout below the tag: length in [TRL_LEN_LSB +: lwidth], truncation flag just above it.
    localparam int TRL_MAX_W   = 64;
    localparam int TRL_LEN_LSB = 0;

    function automatic int trl_trunc_pos(input int lwidth);
        return TRL_LEN_LSB + lwidth;
    endfunction

    function automatic logic [TRL_MAX_W-1:0] pkt_trailer(
        input logic [31:0] len,
        input logic        trunc,
        input int          lwidth
    );
        logic [TRL_MAX_W-1:0] word;
        word = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < lwidth) begin
                word[6'(TRL_LEN_LSB + i)] = len[i];
            end
        end
        word[6'(trl_trunc_pos(lwidth))] = trunc;
        return word;
    endfunction

endpackage

// File: rtl/afifo_pkt_writer_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/afifo_pkt_writer.sv
// Write-side packet framer for the async FIFO: copies payload words and appends a tagged
// length/truncation trailer per packet. Optional counters: define AFIFO_PKT_WRITER_STATS_EN.
module afifo_pkt_writer
    import afifo_pkt_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int MAXLEN = 16
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [WIDTH:0]             fifo_data,
    output logic                       fifo_req,
    input  logic                       fifo_full,
    input  logic [$clog2(DEPTH+1)-1:0] fifo_used,
    output logic [15:0]                stat_pkts,
    output logic [15:0]                stat_trunc
);

    localparam int LWIDTH = $clog2(MAXLEN + 1);
    localparam int FW     = LWIDTH + 2;

    pkt_state_t        state_reg, state_next;
    logic [LWIDTH-1:0] len_reg, len_next;
    logic              trunc_reg, trunc_next;
    logic [FW-1:0]     free;
    logic              admit;

    // Room for a worst-case packet plus its trailer, so a packet is never split by a full FIFO.
    assign free  = FW'(DEPTH) - FW'(fifo_used);
    assign admit = (free >= FW'(MAXLEN + 1));

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            trunc_reg <= trunc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        trunc_next = trunc_reg;
        in_ready   = 1'b0;
        fifo_req   = 1'b0;
        fifo_data  = '0;
        case (state_reg)
            IDLE: begin
                if (in_valid && admit) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready  = ~fifo_full;
                fifo_data = {TAG_PAYLOAD, in_data};
                if (in_valid && !fifo_full) begin
                    fifo_req = 1'b1;
                    len_next = len_reg + 1'b1;
                    if (in_last) begin
                        state_next = TRAIL;
                    end else if (len_reg == LWIDTH'(MAXLEN - 1)) begin
                        trunc_next = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = TRAIL;
                end
            end
            TRAIL: begin
                fifo_data = {TAG_TRAILER, WIDTH'(pkt_trailer(32'(len_reg), trunc_reg, LWIDTH))};
                if (!fifo_full) begin
                    fifo_req   = 1'b1;
                    len_next   = '0;
                    trunc_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef AFIFO_PKT_WRITER_STATS_EN
    logic trail_write;
    assign trail_write = (state_reg == TRAIL) && !fifo_full;

    sat_counter #(.WIDTH(16)) u_pkts (
        .clk   (wr_clk),
        .rst   (wr_rst),
        .inc   (trail_write),
        .count (stat_pkts)
    );

    sat_counter #(.WIDTH(16)) u_trunc (
        .clk   (wr_clk),
        .rst   (wr_rst),
        .inc   (trail_write && trunc_reg),
        .count (stat_trunc)
    );
`else
    assign stat_pkts  = '0;
    assign stat_trunc = '0;
`endif

endmodule

// File: tb/tb_afifo_pkt_writer.sv
// Directed bench for afifo_pkt_writer: table of single-cycle vectors plus multi-cycle packet sequences.
module tb_afifo_pkt_writer;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 64;
    localparam int MAXLEN = 16;

    logic        wr_clk = 1'b0;
    logic        wr_rst;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [32:0] fifo_data;
    logic        fifo_req, fifo_full;
    logic [6:0]  fifo_used;
    logic [15:0] stat_pkts, stat_trunc;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pkts = 0;
    int exp_trunc = 0;

    logic        s_ready, s_req;
    logic [32:0] s_data;
    logic [32:0] cap_q[$];
    logic [32:0] exp_q[$];

    afifo_pkt_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
        .wr_clk     (wr_clk),
        .wr_rst     (wr_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .fifo_data  (fifo_data),
        .fifo_req   (fifo_req),
        .fifo_full  (fifo_full),
        .fifo_used  (fifo_used),
        .stat_pkts  (stat_pkts),
        .stat_trunc (stat_trunc)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        string       name;
        logic        v;
        logic        l;
        logic [31:0] d;
        logic        f;
        logic [6:0]  u;
        logic        e_rdy;
        logic        e_req;
        logic        chk;
        logic [32:0] e_data;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Called at a falling edge: drive, sample before the rising edge, advance one cycle.
    task automatic step(input logic v, input logic l, input logic [31:0] d,
                        input logic f, input logic [6:0] u, output logic acc);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        fifo_full = f;
        fifo_used = u;
        #2;
        s_ready = in_ready;
        s_req   = fifo_req;
        s_data  = fifo_data;
        if (f) check("no_write_while_full", 64'(s_req), 64'd0);
        if (s_req) cap_q.push_back(s_data);
        acc = v & s_ready;
        @(posedge wr_clk);
        @(negedge wr_clk);
    endtask

    function automatic logic [32:0] trailer(input int len, input logic trunc);
        return {1'b1, 32'(len) | (32'(trunc) << 5)};
    endfunction

    task automatic check_writes(input string name);
        check({name, "_nwrites"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic check_stats(input string name);
        int ep, et;
`ifdef AFIFO_PKT_WRITER_STATS_EN
        ep = exp_pkts;
        et = exp_trunc;
`else
        ep = 0;
        et = 0;
`endif
        check({name, "_stat_pkts"}, 64'(stat_pkts), 64'(ep));
        check({name, "_stat_trunc"}, 64'(stat_trunc), 64'(et));
    endtask

    // Full-rate packet of n words; model: first MAXLEN words are written, rest dropped.
    task automatic run_pkt(input string name, input int n, input logic [31:0] base);
        logic acc;
        step(1'b1, 1'b0, base, 1'b0, 7'd0, acc);
        for (int i = 0; i < n; i++) begin
            step(1'b1, (i == n - 1), base + 32'(i), 1'b0, 7'd0, acc);
            if (i >= MAXLEN) check($sformatf("%s_drop_ready%0d", name, i), 64'(s_ready), 64'd1);
            if (i < MAXLEN) exp_q.push_back({1'b0, base + 32'(i)});
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 7'd0, acc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 7'd0, acc);
        exp_q.push_back(trailer((n > MAXLEN) ? MAXLEN : n, n > MAXLEN));
        exp_pkts++;
        if (n > MAXLEN) exp_trunc++;
        check_writes(name);
        check_stats(name);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   budget;

        vecs[0]  = '{"idle_admit",   1, 0, 32'hA0A0_0001, 0, 7'd0,  0, 0, 1, 33'h0};
        vecs[1]  = '{"pay_a",        1, 0, 32'hA0A0_0001, 0, 7'd0,  1, 1, 1, 33'h0_A0A0_0001};
        vecs[2]  = '{"pay_b",        1, 0, 32'hB0B0_0002, 0, 7'd0,  1, 1, 1, 33'h0_B0B0_0002};
        vecs[3]  = '{"pay_c_last",   1, 1, 32'hC0C0_0003, 0, 7'd0,  1, 1, 1, 33'h0_C0C0_0003};
        vecs[4]  = '{"trail_len3",   0, 0, 32'h0,         0, 7'd0,  0, 1, 1, 33'h1_0000_0003};
        vecs[5]  = '{"idle_gap",     0, 0, 32'h0,         0, 7'd0,  0, 0, 1, 33'h0};
        vecs[6]  = '{"idle_admit_d", 1, 1, 32'hD0D0_0004, 1, 7'd0,  0, 0, 1, 33'h0};
        vecs[7]  = '{"pay_full",     1, 1, 32'hD0D0_0004, 1, 7'd0,  0, 0, 0, 33'h0};
        vecs[8]  = '{"pay_d_single", 1, 1, 32'hD0D0_0004, 0, 7'd0,  1, 1, 1, 33'h0_D0D0_0004};
        vecs[9]  = '{"trail_full",   0, 0, 32'h0,         1, 7'd0,  0, 0, 0, 33'h0};
        vecs[10] = '{"trail_len1",   0, 0, 32'h0,         0, 7'd0,  0, 1, 1, 33'h1_0000_0001};
        vecs[11] = '{"idle_used48",  1, 1, 32'hE0E0_0005, 0, 7'd48, 0, 0, 1, 33'h0};
        vecs[12] = '{"idle_used48b", 1, 1, 32'hE0E0_0005, 0, 7'd48, 0, 0, 1, 33'h0};
        vecs[13] = '{"idle_used47",  1, 1, 32'hE0E0_0005, 0, 7'd47, 0, 0, 1, 33'h0};
        vecs[14] = '{"pay_e",        1, 1, 32'hE0E0_0005, 0, 7'd47, 1, 1, 1, 33'h0_E0E0_0005};
        vecs[15] = '{"trail_e",      0, 0, 32'h0,         0, 7'd47, 0, 1, 1, 33'h1_0000_0001};
        vecs[16] = '{"idle_end",     0, 0, 32'h0,         0, 7'd0,  0, 0, 1, 33'h0};

        wr_rst = 1'b1; in_valid = 0; in_last = 0; in_data = 0; fifo_full = 0; fifo_used = 0;
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        check("reset_ready", 64'(in_ready), 64'd0);
        check("reset_req", 64'(fifo_req), 64'd0);
        check("reset_data", 64'(fifo_data), 64'd0);
        check_stats("reset");
        wr_rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].f, vecs[i].u, acc);
            check({vecs[i].name, "_ready"}, 64'(s_ready), 64'(vecs[i].e_rdy));
            check({vecs[i].name, "_req"}, 64'(s_req), 64'(vecs[i].e_req));
            if (vecs[i].chk) check({vecs[i].name, "_data"}, 64'(s_data), 64'(vecs[i].e_data));
        end
        cap_q.delete();
        exp_pkts = 3;
        check_stats("table");

        run_pkt("pkt20_trunc", 20, 32'h1000_0000);
        run_pkt("pkt16_exact", 16, 32'h2000_0000);

        // Random valid gaps and full pulses, then full held for a few cycles in TRAIL.
        step(1'b1, 1'b0, 32'h3000_0000, 1'b0, 7'd0, acc);
        idx = 0;
        budget = 200;
        while (idx < 6 && budget > 0) begin
            step(1'($urandom_range(1)), (idx == 5), 32'h3000_0000 + 32'(idx),
                 ($urandom_range(3) == 0), 7'd0, acc);
            if (acc) idx++;
            budget--;
        end
        check("gaps_budget", 64'(idx), 64'd6);
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 32'h3000_0000 + 32'(i)});
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 7'd0, acc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 7'd0, acc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 7'd0, acc);
        exp_q.push_back(trailer(6, 1'b0));
        exp_pkts++;
        check_writes("gaps");
        check_stats("gaps");

        // Reset in the middle of a packet after two words.
        step(1'b1, 1'b0, 32'h4000_0000, 1'b0, 7'd0, acc);
        step(1'b1, 1'b0, 32'h4000_0000, 1'b0, 7'd0, acc);
        step(1'b1, 1'b0, 32'h4000_0001, 1'b0, 7'd0, acc);
        in_valid = 1'b1; in_data = 32'h4000_0002;
        #2 wr_rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(in_ready), 64'd0);
        check("rst_mid_req", 64'(fifo_req), 64'd0);
        check("rst_mid_data", 64'(fifo_data), 64'd0);
        exp_pkts = 0;
        exp_trunc = 0;
        check_stats("rst_mid");
        @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rst = 1'b0;
        cap_q.delete();
        run_pkt("after_rst", 3, 32'h5000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
